// File: rtl/stmt_lowerer_pkg.sv
// Shared types and helpers for the round-robin statement-lowering arbiter.
package stmt_lowerer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Next channel index in round-robin order, wrapping at n-1 back to 0.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stmt_lowerer_rr_pick.sv
// Rotating-priority picker: scans ptr+1, ptr+2, ... (mod NUM_CH) and reports
// the first channel with a valid request.
module stmt_lowerer_rr_pick
  import stmt_lowerer_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req_valid,
  input  logic [CH_W-1:0]   ptr,
  output logic              found,
  output logic [CH_W-1:0]   winner
);

  logic [CH_W-1:0] cand;

  // Walk the channels after ptr in priority order; stop at the first requester.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    found  = 1'b0;
    winner = '0;
    cand   = ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = CH_W'(rr_next(32'(cand), NUM_CH));
      if (req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
        break;
      end
    end
  end

endmodule

// File: rtl/stmt_lowerer_rr_arbiter.sv
// Round-robin packet arbiter: merges NUM_CH valid/ready streams onto one
// output, holding a grant until packet end or HOLD_MAX beats, with one idle
// bubble between grants.
// Optional trace: define STMT_LOWERER_ARB_TRACE_EN to print grant/release events.
module stmt_lowerer_rr_arbiter
  import stmt_lowerer_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int DATA_W   = 8,
  parameter  int HOLD_MAX = 3,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  input  logic [NUM_CH-1:0]        req_last,
  output logic [NUM_CH-1:0]        req_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  arb_state_e      state, state_d;
  logic [CH_W-1:0] grant, grant_d;
  logic [CH_W-1:0] ptr, ptr_d;
  logic [CNT_W-1:0] beat_cnt, cnt_d, cnt_inc;

  logic            found;
  logic [CH_W-1:0] winner;
  logic            fire;
  logic            hit;

  logic [DATA_W-1:0] ch_data [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_data[c] = req_data[c*DATA_W +: DATA_W];
  end

  stmt_lowerer_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .found     (found),
    .winner    (winner)
  );

  assign busy    = (state == GRANT);
  assign fire    = out_valid & out_ready;
  assign cnt_inc = beat_cnt + 1'b1;
  assign hit     = (cnt_inc == CNT_W'(HOLD_MAX));

  // Output mux: everything is zero unless a channel holds the grant.
  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_ch    = '0;
    if (state == GRANT) begin
      out_valid        = req_valid[grant];
      out_data         = ch_data[grant];
      out_last         = req_last[grant];
      out_ch           = grant;
      req_ready[grant] = out_ready;
    end
  end

  // Next-state: pick in IDLE; in GRANT release on abandon, packet end or budget.
  always_comb begin
    state_d = state;
    grant_d = grant;
    ptr_d   = ptr;
    cnt_d   = beat_cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = winner;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!req_valid[grant]) begin
          // Grantee went idle: give the slot up rather than stall the others.
          state_d = IDLE;
          ptr_d   = grant;
          cnt_d   = '0;
        end else begin
          casez ({fire, req_last[grant], hit})
            3'b11?, 3'b1?1: begin
              state_d = IDLE;
              ptr_d   = grant;
              cnt_d   = '0;
            end
            3'b100:  cnt_d = cnt_inc;
            default: ;
          endcase
        end
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      ptr      <= CH_W'(NUM_CH - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      ptr      <= ptr_d;
      beat_cnt <= cnt_d;
    end
  end

`ifdef STMT_LOWERER_ARB_TRACE_EN
  // Trace grant and release events in the order they take effect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && found)
        $display("grant ch=%0d", winner);
      if (state == GRANT && state_d == IDLE)
        $display("release ch=%0d beats=%0d", grant, fire ? cnt_inc : beat_cnt);
    end
  end
`else
`endif

endmodule

// File: tb/tb_stmt_lowerer_rr_arbiter.sv
// Self-checking bench for stmt_lowerer_rr_arbiter (NUM_CH=4, DATA_W=8, HOLD_MAX=3):
// directed vector table, hand-written corner sequences, then random traffic
// against a transaction-level reference model.
module tb_stmt_lowerer_rr_arbiter;

  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 8;
  localparam int HOLD_MAX = 3;
  localparam logic [31:0] BASE_DATA = 32'hA3A2A1A0;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_last;
  logic        out_ready;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

  stmt_lowerer_rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .DATA_W   (DATA_W),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [3:0] rv, input logic [3:0] rl, input logic ordy);
    rst       = r;
    req_valid = rv;
    req_last  = rl;
    out_ready = ordy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs against an explicit expectation using the fixed payloads.
  task automatic expect_out(input string tag, input logic v, input logic [1:0] ch,
                            input logic [3:0] rdy, input logic b);
    logic [7:0] d;
    logic       l;
    d = b ? 8'(BASE_DATA >> (8 * int'(ch))) : 8'h00;
    l = b ? req_last[ch] : 1'b0;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    check({tag, ".out_ch"},    32'(out_ch),    32'(b ? ch : 2'd0));
    check({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
    check({tag, ".busy"},      32'(busy),      32'(b));
    check({tag, ".out_data"},  32'(out_data),  32'(d));
    check({tag, ".out_last"},  32'(out_last),  32'(l));
  endtask

  // ---------------- reference model (transaction level) ----------------
  int m_owner;  // channel currently holding the output, -1 when none
  int m_last;   // channel most recently served
  int m_beats;  // beats accepted in the current grant

  task automatic model_check(input int cyc);
    logic       e_v, e_l;
    logic [7:0] e_d;
    logic [1:0] e_ch;
    logic [3:0] e_r;
    string      t;
    e_v = 1'b0; e_l = 1'b0; e_d = 8'h00; e_ch = 2'd0; e_r = 4'h0;
    if (m_owner >= 0) begin
      e_ch = 2'(m_owner);
      e_v  = req_valid[e_ch];
      e_l  = req_last[e_ch];
      e_d  = 8'(req_data >> (8 * m_owner));
      e_r  = out_ready ? (4'h1 << m_owner) : 4'h0;
    end
    t = $sformatf("rand[%0d]", cyc);
    check({t, ".out_valid"}, 32'(out_valid), 32'(e_v));
    check({t, ".out_ch"},    32'(out_ch),    32'(e_ch));
    check({t, ".req_ready"}, 32'(req_ready), 32'(e_r));
    check({t, ".busy"},      32'(busy),      32'(m_owner >= 0));
    check({t, ".out_data"},  32'(out_data),  32'(e_d));
    check({t, ".out_last"},  32'(out_last),  32'(e_l));
  endtask

  task automatic model_step();
    if (rst) begin
      m_owner = -1;
      m_last  = NUM_CH - 1;
      m_beats = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        int c = (m_last + k) % NUM_CH;
        if (req_valid[2'(c)]) begin
          m_owner = c;
          m_beats = 0;
          break;
        end
      end
    end else if (!req_valid[2'(m_owner)]) begin
      m_last  = m_owner;
      m_owner = -1;
      m_beats = 0;
    end else if (out_ready) begin
      m_beats++;
      if (req_last[2'(m_owner)] || m_beats == HOLD_MAX) begin
        m_last  = m_owner;
        m_owner = -1;
        m_beats = 0;
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic       rst;
    logic [3:0] rv;
    logic [3:0] rl;
    logic       ordy;
    logic       e_valid;
    logic [1:0] e_ch;
    logic [3:0] e_ready;
    logic       e_busy;
  } vec_t;

  localparam int NTBL = 22;
  vec_t tbl [NTBL];

  initial begin
    // Reset held with everything requesting, then full rotation with 1-beat packets.
    tbl[0]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tbl[1]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1};
    tbl[4]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tbl[5]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1};
    tbl[6]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tbl[7]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1};
    tbl[8]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tbl[9]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1};
    tbl[10] = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tbl[11] = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1};
    // Beat budget: ch2 alone, never last -> 3 beats, bubble, re-grant ch2.
    tbl[12] = '{1'b1, 4'h4, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tbl[13] = '{1'b0, 4'h4, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tbl[14] = '{1'b0, 4'h4, 4'h0, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1};
    tbl[15] = '{1'b0, 4'h4, 4'h0, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1};
    tbl[16] = '{1'b0, 4'h4, 4'h0, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1};
    tbl[17] = '{1'b0, 4'h4, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tbl[18] = '{1'b0, 4'h4, 4'h0, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1};
    tbl[19] = '{1'b0, 4'h4, 4'h0, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1};
    tbl[20] = '{1'b0, 4'h4, 4'h0, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1};
    tbl[21] = '{1'b0, 4'h4, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};

    req_data = BASE_DATA;
    apply(1'b1, 4'hF, 4'hF, 1'b1);
    step();

    for (int i = 0; i < NTBL; i++) begin
      apply(tbl[i].rst, tbl[i].rv, tbl[i].rl, tbl[i].ordy);
      expect_out($sformatf("tbl[%0d]", i), tbl[i].e_valid, tbl[i].e_ch, tbl[i].e_ready, tbl[i].e_busy);
      step();
    end

    // Backpressure: ch1 granted, out_ready low 5 cycles, then budget still 3 beats.
    apply(1'b1, 4'h2, 4'h0, 1'b0); step();
    apply(1'b0, 4'h2, 4'h0, 1'b0);
    expect_out("bp.idle", 1'b0, 2'd0, 4'h0, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 4'h2, 4'h0, 1'b0);
      expect_out($sformatf("bp.stall%0d", i), 1'b1, 2'd1, 4'h0, 1'b1);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 4'h2, 4'h0, 1'b1);
      expect_out($sformatf("bp.beat%0d", i), 1'b1, 2'd1, 4'h2, 1'b1);
      step();
    end
    apply(1'b0, 4'h2, 4'h0, 1'b1);
    expect_out("bp.release", 1'b0, 2'd0, 4'h0, 1'b0);
    step();

    // Abandon: ch3 drops valid mid-packet, ch0 wins after the bubble.
    apply(1'b1, 4'h8, 4'h0, 1'b1); step();
    apply(1'b0, 4'h8, 4'h0, 1'b1);
    expect_out("ab.idle", 1'b0, 2'd0, 4'h0, 1'b0);
    step();
    apply(1'b0, 4'h8, 4'h0, 1'b1);
    expect_out("ab.beat", 1'b1, 2'd3, 4'h8, 1'b1);
    step();
    apply(1'b0, 4'h1, 4'h0, 1'b1);
    expect_out("ab.drop", 1'b0, 2'd3, 4'h8, 1'b1);
    step();
    apply(1'b0, 4'h1, 4'h0, 1'b1);
    expect_out("ab.bubble", 1'b0, 2'd0, 4'h0, 1'b0);
    step();
    apply(1'b0, 4'h1, 4'h0, 1'b1);
    expect_out("ab.ch0", 1'b1, 2'd0, 4'h1, 1'b1);
    step();

    // Reset mid-packet: grant dropped at the reset edge, not resumed.
    apply(1'b1, 4'h1, 4'h0, 1'b1);
    expect_out("rm.during", 1'b1, 2'd0, 4'h1, 1'b1);
    step();
    apply(1'b0, 4'h1, 4'h0, 1'b1);
    expect_out("rm.after", 1'b0, 2'd0, 4'h0, 1'b0);
    step();

    // Random traffic against the reference model.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic [3:0] rl;
      for (int b = 0; b < 4; b++) rl[b] = ($urandom_range(0, 3) == 0);
      req_data = $urandom;
      apply((cyc == 0) || ($urandom_range(0, 49) == 0),
            4'($urandom_range(0, 15)), rl, ($urandom_range(0, 3) != 0));
      if (cyc != 0) model_check(cyc);
      model_step();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
